// File: rtl/camera_param_sync.sv
// Double-buffered camera parameters: the HPS writes the shadow bank, and the active bank
// takes a full copy at the first frame_start after a commit. Optional readback: CAMERA_READBACK_EN.
module camera_param_sync #(
  parameter int                DATA_W  = 27,
  parameter logic [DATA_W-1:0] FIX_ONE = 27'h0100000,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  input  logic              frame_start,
`ifdef CAMERA_READBACK_EN
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
`endif
  output logic              pending,
  output logic              swap_done,
  output logic              wr_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [DATA_W-1:0] eye_x,
  output logic [DATA_W-1:0] eye_y,
  output logic [DATA_W-1:0] eye_z,
  output logic [DATA_W-1:0] look_at_1_1,
  output logic [DATA_W-1:0] look_at_1_2,
  output logic [DATA_W-1:0] look_at_1_3,
  output logic [DATA_W-1:0] look_at_2_1,
  output logic [DATA_W-1:0] look_at_2_2,
  output logic [DATA_W-1:0] look_at_2_3,
  output logic [DATA_W-1:0] look_at_3_1,
  output logic [DATA_W-1:0] look_at_3_2,
  output logic [DATA_W-1:0] look_at_3_3
);

  localparam int NWORDS = 12;

  typedef enum logic {S_IDLE, S_PENDING} state_e;

  // Word 3, 7 and 11 are the matrix diagonal; everything else resets to zero.
  function automatic logic [DATA_W-1:0] reset_word(input int idx);
    return (idx == 3 || idx == 7 || idx == 11) ? FIX_ONE : '0;
  endfunction

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shadow_q [NWORDS];
  logic [DATA_W-1:0] active_q [NWORDS];
  logic              swap_done_q, swap_done_d;
  logic              wr_err_q, wr_err_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              copy_en;
  logic              wr_valid;

  assign wr_valid = wr_en && (wr_addr < 4'd12);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; commit together with frame_start from IDLE copies at once.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (commit && !frame_start) state_d = S_PENDING;
      S_PENDING: if (frame_start)            state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    pending = 1'b0;
    copy_en = 1'b0;
    case (state_q)
      S_IDLE:    copy_en = frame_start && commit;
      S_PENDING: begin
        pending = 1'b1;
        copy_en = frame_start;
      end
      default: ;
    endcase
  end

  // Both banks need a defined camera out of reset, so they cannot live in reset-less RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every word is reset explicitly here; a register file without reset would start as X.
      for (int i = 0; i < NWORDS; i++) begin
        shadow_q[i] <= reset_word(i);
        active_q[i] <= reset_word(i);
      end
    end else begin
      // NOTE: non-blocking, so a copy in the same edge as a write takes the pre-write shadow.
      for (int i = 0; i < NWORDS; i++) begin
        if (wr_valid && wr_addr == 4'(i)) shadow_q[i] <= wr_data;
        if (copy_en)                      active_q[i] <= shadow_q[i];
      end
    end
  end

  always_comb begin
    swap_done_d = copy_en;
    wr_err_d    = wr_err_q || (wr_en && !wr_valid);
    frame_cnt_d = frame_start ? frame_cnt_q + 1'b1 : frame_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swap_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      swap_done_q <= swap_done_d;
      wr_err_q    <= wr_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef CAMERA_READBACK_EN
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NWORDS; i++)
      if (rd_addr == 4'(i)) rd_data_d = shadow_q[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

  assign swap_done   = swap_done_q;
  assign wr_err      = wr_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign eye_x       = active_q[0];
  assign eye_y       = active_q[1];
  assign eye_z       = active_q[2];
  assign look_at_1_1 = active_q[3];
  assign look_at_1_2 = active_q[4];
  assign look_at_1_3 = active_q[5];
  assign look_at_2_1 = active_q[6];
  assign look_at_2_2 = active_q[7];
  assign look_at_2_3 = active_q[8];
  assign look_at_3_1 = active_q[9];
  assign look_at_3_2 = active_q[10];
  assign look_at_3_3 = active_q[11];

endmodule

// File: tb/tb_camera_param_sync.sv
// Self-checking bench for camera_param_sync: directed vector table, reset/wrap sequence,
// then random traffic against a word-array reference model.
module tb_camera_param_sync;

  localparam int          DW  = 27;
  localparam logic [26:0] ONE = 27'h0100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, commit, frame_start;
  logic [3:0]  wr_addr, rd_addr;
  logic [26:0] wr_data;
  logic        pending, swap_done, wr_err;
  logic [15:0] frame_cnt;
  logic [26:0] act [12];
  logic [26:0] rd_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain word arrays and flags updated once per clock edge.
  logic [26:0] m_sh [12];
  logic [26:0] m_ac [12];
  logic        m_pend, m_swap, m_err;
  int          m_cnt;
  logic [26:0] m_rd;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [26:0] wd;
    logic        cm;
    logic        fs;
    logic        e_pend;
    logic        e_swap;
    logic        e_err;
    logic [26:0] e_eyez;
    logic [26:0] e_la11;
    logic [26:0] e_la13;
  } vec_t;

  vec_t tbl [21];

  always #10 clk = ~clk;

  camera_param_sync dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .frame_start(frame_start),
`ifdef CAMERA_READBACK_EN
    .rd_addr(rd_addr), .rd_data(rd_data),
`endif
    .pending(pending), .swap_done(swap_done), .wr_err(wr_err), .frame_cnt(frame_cnt),
    .eye_x(act[0]), .eye_y(act[1]), .eye_z(act[2]),
    .look_at_1_1(act[3]), .look_at_1_2(act[4]), .look_at_1_3(act[5]),
    .look_at_2_1(act[6]), .look_at_2_2(act[7]), .look_at_2_3(act[8]),
    .look_at_3_1(act[9]), .look_at_3_2(act[10]), .look_at_3_3(act[11])
  );

`ifndef CAMERA_READBACK_EN
  assign rd_data = '0;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [26:0] ident(input int i);
    return (i == 3 || i == 7 || i == 11) ? ONE : 27'd0;
  endfunction

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [26:0] wd,
                              input logic cm, input logic fs, input logic ep, input logic es,
                              input logic ee, input logic [26:0] ez, input logic [26:0] l11,
                              input logic [26:0] l13);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.cm = cm; v.fs = fs;
    v.e_pend = ep; v.e_swap = es; v.e_err = ee; v.e_eyez = ez; v.e_la11 = l11; v.e_la13 = l13;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin
      m_sh[i] = ident(i);
      m_ac[i] = ident(i);
    end
    m_pend = 1'b0; m_swap = 1'b0; m_err = 1'b0; m_cnt = 0; m_rd = '0;
  endtask

  task automatic model_step(input logic we, input logic [3:0] wa, input logic [26:0] wd,
                            input logic cm, input logic fs, input logic [3:0] ra);
    logic [26:0] old_sh [12];
    old_sh = m_sh;
    m_swap = fs && (m_pend || cm);
    if (m_swap) m_ac = old_sh;
    m_pend = !m_swap && (m_pend || cm);
    if (we) begin
      if (wa < 12) m_sh[wa] = wd;
      else         m_err = 1'b1;
    end
    if (fs) m_cnt = (m_cnt + 1) % 65536;
    m_rd = (ra < 12) ? old_sh[ra] : 27'd0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".pending"}, 32'(pending), 32'(m_pend));
    check({tag, ".swap_done"}, 32'(swap_done), 32'(m_swap));
    check({tag, ".wr_err"}, 32'(wr_err), 32'(m_err));
    check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
    for (int i = 0; i < 12; i++)
      check($sformatf("%s.word%0d", tag, i), 32'(act[i]), 32'(m_ac[i]));
`ifdef CAMERA_READBACK_EN
    check({tag, ".rd_data"}, 32'(rd_data), 32'(m_rd));
`endif
  endtask

  // Drives one cycle of inputs, advances to just after the edge and steps the model.
  task automatic cycle(input logic we, input logic [3:0] wa, input logic [26:0] wd,
                       input logic cm, input logic fs, input logic [3:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; commit = cm; frame_start = fs; rd_addr = ra;
    @(posedge clk);
    #1;
    model_step(we, wa, wd, cm, fs, ra);
    wr_en = 1'b0; commit = 1'b0; frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; frame_start = 1'b0; rd_addr = '0;
    do_reset();
    @(posedge clk);
    #1;

    // Reset state: identity matrix, zero eye, all flags clear.
    for (int i = 0; i < 12; i++)
      check($sformatf("reset.word%0d", i), 32'(act[i]), 32'(ident(i)));
    check("reset.pending", 32'(pending), 32'd0);
    check("reset.swap_done", 32'(swap_done), 32'd0);
    check("reset.wr_err", 32'(wr_err), 32'd0);
    check("reset.frame_cnt", 32'(frame_cnt), 32'd0);
    check("reset.rd_data", 32'(rd_data), 32'd0);

    // Directed table: delayed commit, zero-wait commit, write in copy cycle, bad address.
    tbl[0] = mk(1, 4'd2, 27'h7FD0000, 0, 0, 0, 0, 0, 27'h0, ONE, 27'h0);
    tbl[1] = mk(0, 4'd0, 27'h0, 1, 0, 1, 0, 0, 27'h0, ONE, 27'h0);
    for (int r = 2; r <= 10; r++)
      tbl[r] = mk(0, 4'd0, 27'h0, 0, 0, 1, 0, 0, 27'h0, ONE, 27'h0);
    tbl[11] = mk(0, 4'd0, 27'h0, 0, 1, 0, 1, 0, 27'h7FD0000, ONE, 27'h0);
    tbl[12] = mk(0, 4'd0, 27'h0, 0, 0, 0, 0, 0, 27'h7FD0000, ONE, 27'h0);
    tbl[13] = mk(1, 4'd3, 27'h0, 0, 0, 0, 0, 0, 27'h7FD0000, ONE, 27'h0);
    tbl[14] = mk(0, 4'd0, 27'h0, 1, 1, 0, 1, 0, 27'h7FD0000, 27'h0, 27'h0);
    tbl[15] = mk(0, 4'd0, 27'h0, 1, 0, 1, 0, 0, 27'h7FD0000, 27'h0, 27'h0);
    tbl[16] = mk(1, 4'd5, 27'h0000123, 0, 1, 0, 1, 0, 27'h7FD0000, 27'h0, 27'h0);
    tbl[17] = mk(0, 4'd0, 27'h0, 1, 1, 0, 1, 0, 27'h7FD0000, 27'h0, 27'h0000123);
    tbl[18] = mk(1, 4'd13, 27'h7FFFFFF, 0, 0, 0, 0, 1, 27'h7FD0000, 27'h0, 27'h0000123);
    tbl[19] = mk(0, 4'd0, 27'h0, 0, 0, 0, 0, 1, 27'h7FD0000, 27'h0, 27'h0000123);
    tbl[20] = mk(0, 4'd0, 27'h0, 1, 1, 0, 1, 1, 27'h7FD0000, 27'h0, 27'h0000123);

    for (int r = 0; r < 21; r++) begin
      cycle(tbl[r].we, tbl[r].wa, tbl[r].wd, tbl[r].cm, tbl[r].fs, 4'd0);
      check($sformatf("tbl%0d.pending", r), 32'(pending), 32'(tbl[r].e_pend));
      check($sformatf("tbl%0d.swap_done", r), 32'(swap_done), 32'(tbl[r].e_swap));
      check($sformatf("tbl%0d.wr_err", r), 32'(wr_err), 32'(tbl[r].e_err));
      check($sformatf("tbl%0d.eye_z", r), 32'(act[2]), 32'(tbl[r].e_eyez));
      check($sformatf("tbl%0d.look_at_1_1", r), 32'(act[3]), 32'(tbl[r].e_la11));
      check($sformatf("tbl%0d.look_at_1_3", r), 32'(act[5]), 32'(tbl[r].e_la13));
    end

    // Reset while a commit is pending: everything back to identity, asynchronously.
    cycle(0, 4'd0, 27'h0, 1, 0, 4'd0);
    check("rst.pending_before", 32'(pending), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst.pending", 32'(pending), 32'd0);
    check("rst.eye_z", 32'(act[2]), 32'd0);
    check("rst.look_at_1_1", 32'(act[3]), 32'(ONE));
    check("rst.look_at_1_3", 32'(act[5]), 32'd0);
    check("rst.wr_err", 32'(wr_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(0, 4'd0, 27'h0, 1, 1, 4'd0);
    check("rst.shadow_eye_z", 32'(act[2]), 32'd0);
    check("rst.shadow_look_at_1_1", 32'(act[3]), 32'(ONE));

    // frame_cnt wrap after 2^16 pulses since reset.
    for (int k = 0; k < 65534; k++)
      cycle(0, 4'd0, 27'h0, 0, 1, 4'd0);
    check("wrap.max", 32'(frame_cnt), 32'h0000FFFF);
    cycle(0, 4'd0, 27'h0, 0, 1, 4'd0);
    check("wrap.zero", 32'(frame_cnt), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic        we, cm, fs;
      logic [3:0]  wa, ra;
      logic [26:0] wd;
      we = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 199) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      wd = 27'($urandom);
      cm = ($urandom_range(0, 5) == 0);
      fs = ($urandom_range(0, 7) == 0);
      ra = 4'($urandom_range(0, 15));
      cycle(we, wa, wd, cm, fs, ra);
      compare_model($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
